// File: rtl/sram_controller_if.sv
// Core-side load/store request bus of the data-memory responder.
// The pipeline (master) holds wr_en/rd_en and samples read_data once ready rises.
// Stalling is expressed solely through ready; there is no separate valid/ack.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit phases on an async external SRAM.
// Latency: a request seen in IDLE completes 2*HALF_CYCLES+1 cycles later (DONE, ready=1).
// Backpressure: ready is low from request acceptance until DONE; the request is latched at accept.
module sram_controller #(
    parameter int HALF_CYCLES = 3,
    parameter int DATA_BASE   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [17:0]         SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);
    localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           op_wr;
    logic [16:0]    word_q;
    logic [31:0]    wdata_q;
    logic [31:0]    read_data_q;
    logic           dq_oe;
    logic [15:0]    dq_out;

    // Byte offset into the SRAM window; only bits [18:2] select the 32-bit word.
    logic [31:0] offset;
    logic        unused_offset_bits;
    assign offset             = bus.address - 32'(DATA_BASE);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    logic req;
    assign req = bus.wr_en | bus.rd_en;

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.read_data = read_data_q;

    // Freeze the pipeline from the accepting IDLE cycle until DONE.
    always_comb begin
        bus.ready = 1'b0;
        case (state)
            IDLE:    bus.ready = ~req;
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // Access sequencer; SRAM pins are registered so each phase's bus values are set on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are high.
                        op_wr     <= bus.wr_en;
                        word_q    <= offset[18:2];
                        wdata_q   <= bus.write_data;
                        cnt       <= '0;
                        state     <= LOW;
                        SRAM_ADDR <= {offset[18:2], 1'b0};
                        SRAM_WE_N <= ~bus.wr_en;
                        SRAM_OE_N <= bus.wr_en;
                        dq_oe     <= bus.wr_en;
                        dq_out    <= bus.write_data[15:0];
                    end
                end
                LOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= HIGH;
                        SRAM_ADDR <= {word_q, 1'b1};
                        dq_out    <= wdata_q[31:16];
                        if (!op_wr) begin
                            read_data_q[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        SRAM_ADDR <= '0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!op_wr) begin
                            read_data_q[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // DONE: a still-high request is only seen as new from IDLE.
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
